// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared types and default sizes for the modular exponentiation controller
package modexp_pkg;

  localparam int W_DEF        = 64;
  localparam int EW_DEF       = 64;
  localparam int STEP_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - square-and-multiply sequencer: operand checks, leading-zero skip, one step per exponent bit
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int EW       = EW_DEF,
  parameter int STEP_LAT = STEP_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] expo,
  input  logic [W-1:0]  modulus,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          err,
  output logic [W-1:0]  step_z,
  output logic [W-1:0]  step_x,
  output logic [W-1:0]  step_n,
  output logic          step_e,
  input  logic [W-1:0]  step_zz
);

  localparam int CW = $clog2(EW + 1);
  localparam int LW = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;

  state_t        state;
  logic [W-1:0]  b;
  logic [W-1:0]  n;
  logic [W-1:0]  acc;
  logic [EW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt;

  // Whole sequencer: step inputs are loaded on entry to ISSUE so they are already
  // stable during the ISSUE cycle and stay untouched across the WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      step_z <= '0;
      step_x <= '0;
      step_n <= '0;
      step_e <= 1'b0;
      b      <= '0;
      n      <= '0;
      acc    <= '0;
      sh     <= '0;
      cnt    <= '0;
      lcnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            b     <= base;
            sh    <= expo;
            n     <= modulus;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          // Operands wider than W/2 bits would overflow the step unit's W-bit product.
          if (n == '0 || n[W-1:W/2] != '0 || b >= n) begin
            err    <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (n == W'(1)) begin
            err    <= 1'b0;
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (sh == '0) begin
            err    <= 1'b0;
            result <= W'(1);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc   <= W'(1);
            cnt   <= CW'(EW);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (sh[EW-1]) begin
            step_z <= acc;
            step_e <= 1'b1;
            step_x <= b;
            step_n <= n;
            state  <= ISSUE;
          end else begin
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
          end
        end
        ISSUE: begin
          lcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (lcnt == LW'(STEP_LAT - 1)) begin
            acc <= step_zz;
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              err    <= 1'b0;
              result <= step_zz;
              done   <= 1'b1;
              step_z <= '0;
              step_x <= '0;
              step_n <= '0;
              step_e <= 1'b0;
              state  <= DONE;
            end else begin
              // Next bit is the one just below the current MSB.
              step_z <= step_zz;
              step_e <= sh[EW-2];
              state  <= ISSUE;
            end
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - scoreboard bench for modexp_ctrl with a behavioural step unit and reference model
module tb_modexp_ctrl;

  localparam int L = 1;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] base = '0, expo = '0, modulus = '0;
  logic        busy, done, err, step_e;
  logic [63:0] result, step_z, step_x, step_n, step_zz;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ndone = 0;
  int   start_cyc = 0;
  exp_t sbq[$];

  modexp_ctrl #(.W(64), .EW(64), .STEP_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .expo(expo), .modulus(modulus),
    .busy(busy), .done(done), .result(result), .err(err),
    .step_z(step_z), .step_x(step_x), .step_n(step_n), .step_e(step_e), .step_zz(step_zz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural step unit with L register stages.
  logic [63:0] pipe [L];
  always @(posedge clk) begin
    if (step_n == 0) pipe[0] <= '0;
    else if (step_e) pipe[0] <= ((step_z * step_z) % step_n) * step_x % step_n;
    else pipe[0] <= (step_z * step_z) % step_n;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign step_zz = pipe[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: right-to-left binary exponentiation plus the documented cycle formula.
  function automatic exp_t model(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
    exp_t r;
    logic [63:0] acc, bb, ee;
    int k;
    r.lat = 2;
    r.err = 1'b0;
    if (n == 0 || (n >> 32) != 0 || b >= n) begin
      r.err = 1'b1;
      r.res = 0;
    end else if (n == 1) begin
      r.res = 0;
    end else if (e == 0) begin
      r.res = 1;
    end else begin
      acc = 1;
      bb = b;
      ee = e;
      while (ee != 0) begin
        if (ee[0]) acc = (acc * bb) % n;
        bb = (bb * bb) % n;
        ee = ee >> 1;
      end
      r.res = acc;
      k = 0;
      for (int i = 63; i >= 0; i--) begin
        if (e[i]) break;
        k++;
      end
      r.lat = 3 + k + (64 - k) * (1 + L);
    end
    return r;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t ex;
      ndone++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done result=%0d", result);
      end else begin
        ex = sbq.pop_front();
        chk("result", result, ex.res);
        chk("err", 64'(err), 64'(ex.err));
        chk("latency", 64'(cyc - start_cyc), 64'(ex.lat));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic run_op(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n,
                        input exp_t ex, input bit hammer);
    int target;
    bit got;
    got = 1'b0;
    sbq.push_back(ex);
    target = ndone + 1;
    @(negedge clk);
    base = b; expo = e; modulus = n; start = 1'b1;
    start_cyc = cyc;
    if (!hammer) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (ndone >= target) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic e, input int lat);
    exp_t x;
    x.res = r; x.err = e; x.lat = lat;
    return x;
  endfunction

  initial begin
    logic [63:0] rb, re, rn;
    int c0;
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_step_n", step_n, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4, 13, 497, mk(445, 0, 71), 0);
    run_op(2, 64'd1000000006, 64'd1000000007, mk(1, 0, 97), 0);
    run_op(3, 0, 7, mk(1, 0, 2), 0);
    run_op(0, 5, 1, mk(0, 0, 2), 0);
    run_op(3, 5, 0, mk(0, 1, 2), 0);
    run_op(3, 5, 64'h1_0000_0000, mk(0, 1, 2), 0);
    run_op(10, 5, 7, mk(0, 1, 2), 0);
    run_op(4, 13, 497, mk(445, 0, 71), 1);
    run_op(5, 3, 13, model(5, 3, 13), 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: rn = 64'($urandom_range(2, 1000));
        1: rn = 64'($urandom) | 64'h2;
        2: rn = 64'($urandom_range(1, 3));
        default: rn = {32'($urandom_range(0, 1)), 32'($urandom)};
      endcase
      rb = (rn > 1 && $urandom_range(0, 7) != 0) ? 64'($urandom) % rn : 64'($urandom_range(0, 20));
      re = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 64);
      run_op(rb, re, rn, model(rb, re, rn), 0);
    end

    // Reset in the middle of the first WAIT cycle: expo=0xFFFF has 48 leading zeros.
    sbq.push_back(mk(0, 0, 0));
    @(negedge clk);
    base = 3; expo = 64'hFFFF; modulus = 7; start = 1'b1;
    c0 = cyc;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && cyc < c0 + 52; i++) @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    chk("mid_step_n", step_n, 7);
    #1 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_err", 64'(err), 0);
    chk("abort_result", result, 0);
    chk("abort_step_z", step_z, 0);
    chk("abort_step_x", step_x, 0);
    chk("abort_step_n", step_n, 0);
    chk("abort_step_e", 64'(step_e), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_op(3, 5, 7, mk(5, 0, 70), 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencing controller for modular exponentiation, result = base^expo mod modulus, built on the team's one-bit square-and-multiply step unit. It validates operands, skips leading zeros of the exponent, then issues one step per remaining exponent bit, MSB first. Between steps it holds the step inputs stable for the step latency, and it captures the running accumulator from the step output. It sits between the command interface (start/done) and the step datapath, which lives outside this block.

## Interface
- W, 64: operand width (base, modulus, accumulator).
- EW, 64: exponent width.
- STEP_LAT, 1: clocks from stable step inputs to a valid step_zz.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- base  in  W  base, latched on accepted start
- expo  in  EW  exponent, latched on accepted start
- modulus  in  W  modulus, latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse; result/err are valid in that cycle
- result  out  W  registered; held until the next done
- err  out  1  operand error; registered, held until the next done
- step_z  out  W  accumulator to the step unit
- step_x  out  W  latched base
- step_n  out  W  latched modulus
- step_e  out  1  current exponent bit
- step_zz  in  W  step result: (z² mod n)·x mod n if e, else z² mod n

## Operation
- States: IDLE → CHECK → SCAN → ISSUE ⇄ WAIT → DONE → IDLE.
- IDLE:
  - step_* outputs are 0.
  - When start=1: latch operands into b, sh (exponent shift register) and n, then go to CHECK.
- CHECK: the first matching condition wins.
  - err=1, result=0, go to DONE when:
    - n==0;
    - n[W-1:W/2]≠0 (operands must fit W/2 bits so the W-bit product does not truncate);
    - b≥n.
  - Else if n==1: result=0, go to DONE.
  - Else if sh==0: result=1, go to DONE.
  - Else: acc=1, cnt=EW, go to SCAN.
- SCAN:
  - If sh[EW-1]=1, go to ISSUE.
  - Else shift sh left by 1, decrement cnt, stay in SCAN.
- ISSUE:
  - Drive step_z=acc, step_e=sh[EW-1], step_x=b, step_n=n.
  - These values are held unchanged through the following WAIT cycles.
- WAIT:
  - Count STEP_LAT cycles.
  - On the last WAIT cycle, capture acc←step_zz, shift sh left, decrement cnt.
  - If cnt (after decrement) is 0, go to DONE; else go to ISSUE.
- DONE:
  - result←acc (normal path); done=1 for exactly one cycle; go to IDLE.
  - A start asserted during DONE is ignored.
- start while busy: ignored; there is no queueing.
- Reset (any time, including mid-operation):
  - state=IDLE; busy, done, err, result and step_* all 0; acc, sh, cnt cleared.
  - An aborted operation never produces done.

## Timing
- Notation: start is sampled in cycle 0. k = number of leading zeros of expo. m = EW−k = number of significant exponent bits.
- Error and trivial paths: done in cycle 2.
- Normal path:
  - SCAN occupies k+1 cycles.
  - Each bit takes 1+STEP_LAT cycles.
  - done in cycle 3+k+m·(1+STEP_LAT).
- Next start is accepted no earlier than the cycle after done.

## Structure
- Package modexp_pkg holds:
  - the state enum (IDLE, CHECK, SCAN, ISSUE, WAIT, DONE);
  - default W/EW/STEP_LAT constants.
- The controller itself is flat.
- One wrapper, modexp_top, is natural: it instantiates modexp_ctrl plus the existing square-and-multiply step unit, connected via step_*.
- The bench targets modexp_top.

## Test plan
- base=4, expo=13, modulus=497 (EW=64, STEP_LAT=1) → result=445, err=0, done in cycle 71 (k=60, m=4).
- base=2, expo=1000000006, modulus=1000000007 → result=1, done in cycle 97 (k=34, m=30).
- Trivial paths, each with done in cycle 2 and err=0:
  - expo=0, modulus=7 → result=1;
  - expo=5, modulus=1 → result=0.
- Error paths, each with err=1, result=0, done in cycle 2:
  - modulus=0;
  - modulus=2^32;
  - base=10 with modulus=7.
- start pulsed every cycle during a busy operation, and in its DONE cycle → exactly one done, correct result; the following start accepted normally.
- rst_n asserted in the middle of a WAIT cycle → all outputs 0 immediately, no done; a new start after release computes 3^5 mod 7 = 5.
